mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DWIDTH, default 32, data width of all data ports.
REQ-002 Parameter AWIDTH, default 32, address width of all address ports.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_req  input  1  fetch request; held high with i_addr stable until i_ack.
REQ-006 i_addr  input  AWIDTH  fetch address (word read).
REQ-007 i_ack  output  1  one-cycle pulse; i_rdata valid in the same cycle.
REQ-008 i_rdata  output  DWIDTH  fetched instruction.
REQ-009 d_req  input  1  data request; held high with d_addr/d_we/d_size/d_wdata stable until d_ack.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  AWIDTH  data address.
REQ-012 d_size  input  3  access size code, passed through unchanged.
REQ-013 d_wdata  input  DWIDTH  store data.
REQ-014 d_ack  output  1  one-cycle pulse; d_rdata valid in the same cycle.
REQ-015 d_rdata  output  DWIDTH  load data; for stores its value is don't-care.
REQ-016 mem_req  output  1  request to the unified single-port memory; held until mem_rdy.
REQ-017 mem_we / mem_addr / mem_size / mem_wdata  output  1/AWIDTH/3/DWIDTH  registered command to memory.
REQ-018 mem_rdy  input  1  memory completion; mem_rdata valid in this cycle.
REQ-019 mem_rdata  input  DWIDTH  memory read data.
REQ-020 stall  output  1  pipeline freeze request to the core.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, BUSY, RESP.
REQ-022 In IDLE with any request pending, the arbiter SHALL pick a winner, register the winner's command into mem_* and move to BUSY on the next edge.
- Fetch commands use mem_we=0, mem_size=3'b010, mem_wdata=0.
REQ-023 In BUSY, mem_req SHALL be 1 and the mem_* outputs SHALL be held constant.
- On mem_rdy=1: capture mem_rdata and move to RESP.
REQ-024 In RESP, the arbiter SHALL pulse the winner's ack for exactly one cycle with the captured data, then return to IDLE.
REQ-025 With zero-wait memory (mem_rdy=1 in the first BUSY cycle), latency from req to ack SHALL be 2 cycles; each memory wait cycle SHALL add 1.
REQ-026 Fixed priority (default): when both requests are pending in IDLE, d_req SHALL win.
REQ-027 A requester that loses arbitration SHALL be served in the IDLE cycle immediately after the winner's RESP, if still requesting.
REQ-028 stall SHALL be combinational: (i_req & ~i_ack) | (d_req & ~d_ack).
REQ-029 Dropping a request before its ack is illegal; the arbiter SHALL still complete the transaction and SHALL suppress the ack.
REQ-030 mem_rdy outside BUSY SHALL be ignored.
REQ-031 A request that arrives during RESP SHALL NOT be granted until the following IDLE cycle.

Reset
REQ-032 When rst=1, on the clock edge the FSM SHALL go to IDLE and clear the following to 0: mem_req, mem_we, mem_addr, mem_size, mem_wdata, i_ack, d_ack, i_rdata, d_rdata and the last-grant flag.
REQ-033 Reset during BUSY or RESP SHALL abandon the transaction with no ack; requesters re-present their requests after reset.

Configuration
REQ-034 Macro MEM_ARB_RR_EN selects the arbitration policy.
- Defined: round-robin. A 1-bit last-grant register is updated on each grant; on a tie, the port not granted last wins.
- Undefined: fixed D-priority per REQ-026; the last-grant register is not built.

Structure
REQ-035 A shared package SHALL hold the state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), the constant SIZE_WORD=3'b010 and the port-select encoding (SEL_I=0, SEL_D=1).
REQ-036 One combinational sub-module, arb_pick, SHALL compute the winner from i_req, d_req and last_grant; all state SHALL live in mem_arbiter.

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- Lone fetch, i_addr=0x100, mem_rdy tied 1, mem_rdata=0x00500093: i_ack in cycle 2, i_rdata=0x00500093, stall high in cycles 0-1.
- Both i_req and d_req (load 0x2000) in the same cycle, fixed mode: d served first (d_ack cycle 2), i served next (i_ack cycle 5).
- Same stimulus with MEM_ARB_RR_EN and last_grant=D: i_ack cycle 2, then d_ack cycle 5.
- Store with d_addr=0x2004, d_wdata=0xDEADBEEF, d_size=3'b010 and 3 wait cycles: mem_we=1 and mem_* stable for 4 BUSY cycles, then d_ack in cycle 5.
- rst asserted in the second BUSY cycle: the next cycle is IDLE, mem_req=0, and no ack is ever issued for that request.
- Stray mem_rdy pulse in IDLE: no state change and no ack.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] SIZE_WORD = 3'b010;

   localparam logic SEL_I = 1'b0;
   localparam logic SEL_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side fetch/data ports and memory-side command bus of the arbiter.
interface mem_arbiter_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
);
   logic              i_req;
   logic [AWIDTH-1:0] i_addr;
   logic              i_ack;
   logic [DWIDTH-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [AWIDTH-1:0] d_addr;
   logic [2:0]        d_size;
   logic [DWIDTH-1:0] d_wdata;
   logic              d_ack;
   logic [DWIDTH-1:0] d_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [AWIDTH-1:0] mem_addr;
   logic [2:0]        mem_size;
   logic [DWIDTH-1:0] mem_wdata;
   logic              mem_rdy;
   logic [DWIDTH-1:0] mem_rdata;

   logic              stall;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_size, d_wdata, mem_rdy, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata,
      output mem_req, mem_we, mem_addr, mem_size, mem_wdata, stall
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_size, d_wdata, mem_rdy, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata,
      input  mem_req, mem_we, mem_addr, mem_size, mem_wdata, stall
   );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Winner select between fetch and data ports.
// MEM_ARB_RR_EN: ties go to the port not granted last; otherwise data always wins.
module arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic last_grant,
   output logic any_req,
   output logic sel
);

`ifndef MEM_ARB_RR_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   always_comb begin
      any_req = i_req | d_req;
      sel     = d_req ? SEL_D : SEL_I;
      if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
         sel = ~last_grant;
`else
         sel = SEL_D;
`endif
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port memory: IDLE -> BUSY -> RESP.
// MEM_ARB_RR_EN builds a last-grant register and round-robin tie-breaking.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   state_t            state, state_n;
   logic              grant, done;
   logic              any_req, pick_sel;
   logic              sel_q, win_req, dropped;
   logic              last_grant;
   logic [AWIDTH-1:0] cmd_addr;
   logic [DWIDTH-1:0] cmd_wdata;
   logic [2:0]        cmd_size;
   logic              cmd_we;

   arb_pick u_pick (
      .i_req      (bus.i_req),
      .d_req      (bus.d_req),
      .last_grant (last_grant),
      .any_req    (any_req),
      .sel        (pick_sel)
   );

   assign cmd_addr  = (pick_sel == SEL_D) ? bus.d_addr  : bus.i_addr;
   assign cmd_wdata = (pick_sel == SEL_D) ? bus.d_wdata : '0;
   assign cmd_size  = (pick_sel == SEL_D) ? bus.d_size  : SIZE_WORD;
   assign cmd_we    = (pick_sel == SEL_D) & bus.d_we;

   assign win_req   = (sel_q == SEL_D) ? bus.d_req : bus.i_req;
   assign bus.stall = (bus.i_req & ~bus.i_ack) | (bus.d_req & ~bus.d_ack);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // mem_rdy is only looked at in BUSY; grants are only made in IDLE.
   always_comb begin
      state_n = state;
      grant   = 1'b0;
      done    = 1'b0;
      case (state)
         IDLE: if (any_req) begin
            state_n = BUSY;
            grant   = 1'b1;
         end
         BUSY: if (bus.mem_rdy) begin
            state_n = RESP;
            done    = 1'b1;
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

`ifdef MEM_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (rst)        last_grant <= 1'b0;
      else if (grant) last_grant <= pick_sel;
   end
`else
   assign last_grant = SEL_D;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_size  <= '0;
         bus.mem_wdata <= '0;
         bus.i_ack     <= 1'b0;
         bus.d_ack     <= 1'b0;
         bus.i_rdata   <= '0;
         bus.d_rdata   <= '0;
         sel_q         <= SEL_I;
         dropped       <= 1'b0;
      end else begin
         bus.i_ack <= 1'b0;
         bus.d_ack <= 1'b0;
         if (grant) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= cmd_we;
            bus.mem_addr  <= cmd_addr;
            bus.mem_size  <= cmd_size;
            bus.mem_wdata <= cmd_wdata;
            sel_q         <= pick_sel;
            dropped       <= 1'b0;
         end
         // An abandoned request still runs to completion but gets no ack.
         if (state == BUSY && !win_req) dropped <= 1'b1;
         if (done) begin
            bus.mem_req <= 1'b0;
            bus.i_ack   <= (sel_q == SEL_I) & win_req & ~dropped;
            bus.d_ack   <= (sel_q == SEL_D) & win_req & ~dropped;
            if (sel_q == SEL_I) bus.i_rdata <= bus.mem_rdata;
            else                bus.d_rdata <= bus.mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios, memory responder with waits.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter_if #(.DWIDTH(32), .AWIDTH(32)) mif ();

   mem_arbiter #(.DWIDTH(32), .AWIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (mif)
   );

   typedef struct {
      logic        port;
      logic [31:0] data;
      logic        chk_data;
      int          cyc;
   } exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } cmd_t;

   exp_t sb[$];
   cmd_t cq[$];
   cmd_t cur;

   int   total = 0;
   int   bad   = 0;
   int   mem_wait = 0;
   int   busy_cnt = 0;
   int   bcnt = 0;
   int   c0 = 0;
   logic stray = 1'b0;
   logic last_stall, last_memreq;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h100) return 32'h0050_0093;
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic exp_ack(input logic port, input logic [31:0] data, input logic cd, input int c);
      exp_t e;
      e.port = port; e.data = data; e.chk_data = cd; e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic exp_cmd(input logic we, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
      cmd_t c;
      c.we = we; c.addr = a; c.size = sz; c.wdata = wd;
      cq.push_back(c);
   endtask

   // One clock: sample/check at negedge, answer memory, then drop acked requests.
   task automatic step();
      exp_t e;
      cmd_t c;
      logic hit_i, hit_d;
      @(negedge clk);
      last_stall  = mif.stall;
      last_memreq = mif.mem_req;
      hit_i = mif.i_ack;
      hit_d = mif.d_ack;
      if (hit_i || hit_d) begin
         chk("dual_ack", 32'(hit_i & hit_d), 32'h0);
         if (sb.size() == 0) chk("unexp_ack", {30'b0, hit_i, hit_d}, 32'h0);
         else begin
            e = sb.pop_front();
            chk("ack_port", 32'(hit_d), 32'(e.port));
            chk("ack_cycle", 32'(cyc), 32'(e.cyc));
            if (e.chk_data) chk("ack_data", hit_d ? mif.d_rdata : mif.i_rdata, e.data);
         end
      end
      if (mif.mem_req) begin
         bcnt++;
         if (busy_cnt == 0) begin
            cur.we = mif.mem_we; cur.addr = mif.mem_addr;
            cur.size = mif.mem_size; cur.wdata = mif.mem_wdata;
            if (cq.size() == 0) chk("unexp_cmd", 32'(cq.size()), 32'h1);
            else begin
               c = cq.pop_front();
               chk("cmd_addr", cur.addr, c.addr);
               chk("cmd_we_size", {28'b0, cur.we, cur.size}, {28'b0, c.we, c.size});
               chk("cmd_wdata", cur.wdata, c.wdata);
            end
         end else begin
            chk("hold_addr", mif.mem_addr, cur.addr);
            chk("hold_we_size", {28'b0, mif.mem_we, mif.mem_size}, {28'b0, cur.we, cur.size});
            chk("hold_wdata", mif.mem_wdata, cur.wdata);
         end
         mif.mem_rdy   = (busy_cnt == mem_wait);
         mif.mem_rdata = mif.mem_rdy ? mem_val(mif.mem_addr) : 32'hBAD0_BAD0;
         busy_cnt++;
      end else begin
         busy_cnt      = 0;
         mif.mem_rdy   = stray;
         mif.mem_rdata = 32'hBAD0_BAD0;
      end
      @(posedge clk);
      #1;
      if (hit_i) mif.i_req = 1'b0;
      if (hit_d) mif.d_req = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && sb.size() != 0; k++) step();
      if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'h0);
   endtask

   task automatic load(input logic [31:0] a, input logic [2:0] sz);
      mif.d_req = 1'b1; mif.d_we = 1'b0; mif.d_addr = a;
      mif.d_size = sz;  mif.d_wdata = 32'h0;
   endtask

   initial begin
      mif.i_req = 1'b0; mif.i_addr = '0;
      mif.d_req = 1'b0; mif.d_we = 1'b0; mif.d_addr = '0;
      mif.d_size = '0;  mif.d_wdata = '0;
      mif.mem_rdy = 1'b0; mif.mem_rdata = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_req", 32'(mif.mem_req), 32'h0);
      chk("rst_mem_addr", mif.mem_addr, 32'h0);
      chk("rst_acks", {30'b0, mif.i_ack, mif.d_ack}, 32'h0);
      chk("rst_rdata", mif.i_rdata | mif.d_rdata, 32'h0);
      chk("rst_stall", 32'(mif.stall), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      step();

      // lone fetch, zero-wait
      mif.i_addr = 32'h100; mif.i_req = 1'b1; c0 = cyc;
      exp_cmd(1'b0, 32'h100, 3'b010, 32'h0);
      exp_ack(1'b0, 32'h0050_0093, 1'b1, c0 + 2);
      step(); chk("f_stall_c0", 32'(last_stall), 32'h1);
      step(); chk("f_stall_c1", 32'(last_stall), 32'h1);
      drain(); chk("f_stall_ack", 32'(last_stall), 32'h0);

      // lone load leaves last grant on D
      load(32'h1000, 3'b010); c0 = cyc;
      exp_cmd(1'b0, 32'h1000, 3'b010, 32'h0);
      exp_ack(1'b1, mem_val(32'h1000), 1'b1, c0 + 2);
      drain();

      // simultaneous fetch and load
      mif.i_addr = 32'h300; mif.i_req = 1'b1;
      load(32'h2000, 3'b010); c0 = cyc;
`ifdef MEM_ARB_RR_EN
      exp_cmd(1'b0, 32'h300, 3'b010, 32'h0);
      exp_cmd(1'b0, 32'h2000, 3'b010, 32'h0);
      exp_ack(1'b0, mem_val(32'h300), 1'b1, c0 + 2);
      exp_ack(1'b1, mem_val(32'h2000), 1'b1, c0 + 5);
`else
      exp_cmd(1'b0, 32'h2000, 3'b010, 32'h0);
      exp_cmd(1'b0, 32'h300, 3'b010, 32'h0);
      exp_ack(1'b1, mem_val(32'h2000), 1'b1, c0 + 2);
      exp_ack(1'b0, mem_val(32'h300), 1'b1, c0 + 5);
`endif
      drain();
      step();

      // store with 3 wait cycles
      mem_wait = 3; bcnt = 0;
      mif.d_req = 1'b1; mif.d_we = 1'b1; mif.d_addr = 32'h2004;
      mif.d_size = 3'b010; mif.d_wdata = 32'hDEAD_BEEF; c0 = cyc;
      exp_cmd(1'b1, 32'h2004, 3'b010, 32'hDEAD_BEEF);
      exp_ack(1'b1, 32'h0, 1'b0, c0 + 5);
      drain();
      chk("st_busy_cycles", 32'(bcnt), 32'd4);
      mif.d_we = 1'b0;

      // byte load, one wait cycle, size passed through
      mem_wait = 1;
      load(32'h2010, 3'b000); c0 = cyc;
      exp_cmd(1'b0, 32'h2010, 3'b000, 32'h0);
      exp_ack(1'b1, mem_val(32'h2010), 1'b1, c0 + 3);
      drain();

      // reset in the second BUSY cycle
      mem_wait = 3;
      load(32'h2008, 3'b010);
      exp_cmd(1'b0, 32'h2008, 3'b010, 32'h0);
      step(); step();
      rst = 1'b1; mif.d_req = 1'b0;
      step();
      rst = 1'b0;
      step();
      chk("rb_mem_req", 32'(last_memreq), 32'h0);
      chk("rb_d_rdata", mif.d_rdata, 32'h0);
      repeat (6) step();
      mem_wait = 0;

      // stray mem_rdy while idle
      stray = 1'b1;
      step();
      stray = 1'b0;
      step();
      chk("stray_mem_req", 32'(last_memreq), 32'h0);
      chk("stray_stall", 32'(last_stall), 32'h0);
      mif.i_addr = 32'h104; mif.i_req = 1'b1; c0 = cyc;
      exp_cmd(1'b0, 32'h104, 3'b010, 32'h0);
      exp_ack(1'b0, mem_val(32'h104), 1'b1, c0 + 2);
      drain();

      // fetch abandoned mid-transaction: completes, no ack
      mem_wait = 2;
      mif.i_addr = 32'h400; mif.i_req = 1'b1;
      exp_cmd(1'b0, 32'h400, 3'b010, 32'h0);
      step(); step();
      mif.i_req = 1'b0;
      repeat (6) step();
      mem_wait = 0;

      chk("sb_left", 32'(sb.size()), 32'h0);
      chk("cmd_left", 32'(cq.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
